// File: rtl/aria_round_seq_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : aria_round_seq_if
// Brief    : Command / address-unit / round-datapath signal bundle of the
//            ARIA round sequencer.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface aria_round_seq_if;
    logic       kexp_start;
    logic       crypt_start;
    logic [1:0] ksize;
    logic       dec;
    logic       abort;
    logic       rnd_ack;
    logic [1:0] rk_op;
    logic       rk_en;
    logic       rk_clr;
    logic [1:0] st_ksize;
    logic       flg_dec;
    logic       key_we;
    logic       rnd_go;
    logic [4:0] rnd_cnt;
    logic       rnd_last;
    logic       key_valid;
    logic       busy;
    logic       done;
    logic       err;

    modport slave (
        input  kexp_start, crypt_start, ksize, dec, abort, rnd_ack,
        output rk_op, rk_en, rk_clr, st_ksize, flg_dec, key_we, rnd_go,
               rnd_cnt, rnd_last, key_valid, busy, done, err
    );

    modport master (
        output kexp_start, crypt_start, ksize, dec, abort, rnd_ack,
        input  rk_op, rk_en, rk_clr, st_ksize, flg_dec, key_we, rnd_go,
               rnd_cnt, rnd_last, key_valid, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/aria_round_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : aria_round_seq
// Brief    : Sequencer for the ARIA round-key address unit and round datapath
//            (key expansion write strobes, handshaked per-round key-add steps).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module aria_round_seq (
    input  wire logic       clk,
    input  wire logic       rst,
    aria_round_seq_if.slave bus
);
    localparam logic [1:0] c_OP_K_INIT = 2'b00;
    localparam logic [1:0] c_OP_K_NEXT = 2'b01;
    localparam logic [1:0] c_OP_R_INIT = 2'b10;
    localparam logic [1:0] c_OP_R_NEXT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_K_INIT = 3'd1,
        S_K_RUN  = 3'd2,
        S_R_INIT = 3'd3,
        S_R_REQ  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t     r_state;
    logic [4:0] r_cnt;
    logic [1:0] r_st_ksize;
    logic       r_flg_dec;
    logic       r_key_valid;

    logic [4:0] w_nr;
    logic       w_abort;
    logic       w_idle;

    // NK-1 equals NR, so one terminal count serves both phases.
    always_comb begin
        case (r_st_ksize)
            2'b10:   w_nr = 5'd14;
            2'b11:   w_nr = 5'd16;
            default: w_nr = 5'd12;
        endcase
    end

    assign w_idle  = (r_state == S_IDLE);
    assign w_abort = bus.abort && !w_idle;

    assign bus.busy      = !w_idle;
    assign bus.st_ksize  = r_st_ksize;
    assign bus.flg_dec   = r_flg_dec;
    assign bus.key_valid = r_key_valid;
    assign bus.rnd_cnt   = r_cnt;
    assign bus.err       = w_idle &&
                           ((bus.kexp_start && (bus.ksize == 2'b00)) ||
                            (!bus.kexp_start && bus.crypt_start && !r_key_valid));

    always_comb begin
        bus.rk_op    = c_OP_K_INIT;
        bus.rk_en    = 1'b0;
        bus.rk_clr   = 1'b0;
        bus.key_we   = 1'b0;
        bus.rnd_go   = 1'b0;
        bus.rnd_last = 1'b0;
        bus.done     = 1'b0;
        if (w_abort) begin
            bus.rk_clr = 1'b1;
        end else begin
            case (r_state)
                S_K_INIT: begin
                    bus.rk_en = 1'b1;
                    bus.rk_op = c_OP_K_INIT;
                end
                S_K_RUN: begin
                    bus.key_we   = 1'b1;
                    bus.rnd_last = (r_cnt == w_nr);
                    if (r_cnt < w_nr) begin
                        bus.rk_en = 1'b1;
                        bus.rk_op = c_OP_K_NEXT;
                    end
                end
                S_R_INIT: begin
                    bus.rk_en = 1'b1;
                    bus.rk_op = c_OP_R_INIT;
                end
                S_R_REQ: begin
                    bus.rnd_go   = 1'b1;
                    bus.rnd_last = (r_cnt == w_nr);
                    if (bus.rnd_ack && (r_cnt < w_nr)) begin
                        bus.rk_en = 1'b1;
                        bus.rk_op = c_OP_R_NEXT;
                    end
                end
                S_DONE: begin
                    bus.done   = 1'b1;
                    bus.rk_clr = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 5'd0;
            r_st_ksize  <= 2'b00;
            r_flg_dec   <= 1'b0;
            r_key_valid <= 1'b0;
        end else if (w_abort) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Key expansion has priority; a simultaneous crypt start is dropped.
                    if (bus.kexp_start) begin
                        if (bus.ksize != 2'b00) begin
                            r_st_ksize  <= bus.ksize;
                            r_key_valid <= 1'b0;
                            r_state     <= S_K_INIT;
                        end
                    end else if (bus.crypt_start && r_key_valid) begin
                        r_flg_dec <= bus.dec;
                        r_state   <= S_R_INIT;
                    end
                end
                S_K_INIT: begin
                    r_cnt   <= 5'd0;
                    r_state <= S_K_RUN;
                end
                S_K_RUN: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == w_nr) begin
                        r_key_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_R_INIT: begin
                    r_cnt   <= 5'd0;
                    r_state <= S_R_REQ;
                end
                S_R_REQ: begin
                    if (bus.rnd_ack) begin
                        if (r_cnt == w_nr) begin
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_aria_round_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_aria_round_seq
// Brief    : Self-checking bench for aria_round_seq: command vector table,
//            directed multi-cycle sequences and randomized command mix.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_aria_round_seq;
    logic clk = 1'b0;
    logic rst;

    aria_round_seq_if bus ();
    aria_round_seq dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state of the command-level model.
    bit         kv_m;
    logic [1:0] ks_m;

    typedef struct {
        bit         kexp;
        bit         crypt;
        logic [1:0] ks;
        bit         dec;
        bit         abrt;
        bit         finish;
        bit         e_err;
        bit         e_busy;
        bit         e_kv;
        bit         e_kv_end;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.kexp_start  = 1'b0;
        bus.crypt_start = 1'b0;
        bus.ksize       = 2'b00;
        bus.dec         = 1'b0;
        bus.abort       = 1'b0;
        bus.rnd_ack     = 1'b0;
    endtask

    function automatic int nr_of(input logic [1:0] ks);
        case (ks)
            2'b10:   return 14;
            2'b11:   return 16;
            default: return 12;
        endcase
    endfunction

    task automatic chk_ctl(input string tag, input bit we, input bit go, input logic [1:0] op,
                           input bit en, input bit clr, input bit last, input bit dn, input bit bsy);
        chk({tag, ".key_we"},   bus.key_we,   we);
        chk({tag, ".rnd_go"},   bus.rnd_go,   go);
        chk({tag, ".rk_op"},    bus.rk_op,    op);
        chk({tag, ".rk_en"},    bus.rk_en,    en);
        chk({tag, ".rk_clr"},   bus.rk_clr,   clr);
        chk({tag, ".rnd_last"}, bus.rnd_last, last);
        chk({tag, ".done"},     bus.done,     dn);
        chk({tag, ".busy"},     bus.busy,     bsy);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_ctl(tag, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        chk({tag, ".st_ksize"},  bus.st_ksize,  0);
        chk({tag, ".flg_dec"},   bus.flg_dec,   0);
        chk({tag, ".rnd_cnt"},   bus.rnd_cnt,   0);
        chk({tag, ".key_valid"}, bus.key_valid, 0);
        chk({tag, ".err"},       bus.err,       0);
    endtask

    // Called at a negedge while the sequencer is busy.
    task automatic do_abort(input string tag);
        bus.abort = 1'b1;
        #1;
        chk({tag, ".rk_clr"}, bus.rk_clr, 1);
        chk({tag, ".rk_en"},  bus.rk_en,  0);
        chk({tag, ".done"},   bus.done,   0);
        step();
        bus.abort = 1'b0;
        #1;
        chk({tag, ".busy_after"}, bus.busy,      0);
        chk({tag, ".kv_after"},   bus.key_valid, kv_m);
    endtask

    task automatic wait_done(input string tag, input int lim);
        bit seen = 1'b0;
        for (int c = 0; c < lim && !seen; c++) begin
            #1;
            if (bus.done === 1'b1) seen = 1'b1;
            step();
        end
        chk({tag, ".done_seen"}, 32'(seen), 1);
    endtask

    // abort_at: 0 = K_INIT cycle, i+1 = K_RUN cycle with key index i, -1 = none.
    task automatic run_kexp(input logic [1:0] ks, input int abort_at);
        int nk = nr_of(ks) + 1;
        bus.kexp_start = 1'b1;
        bus.ksize      = ks;
        #1;
        chk("kexp.err", bus.err, 0);
        step();
        bus.kexp_start = 1'b0;
        bus.ksize      = 2'b00;
        kv_m = 1'b0;
        ks_m = ks;
        if (abort_at == 0) begin
            do_abort("kabort_init");
            return;
        end
        #1;
        chk_ctl("kinit", 0, 0, 2'b00, 1, 0, 0, 0, 1);
        step();
        for (int i = 0; i < nk; i++) begin
            if (abort_at == i + 1) begin
                do_abort("kabort_run");
                return;
            end
            #1;
            chk_ctl("krun", 1, 0, (i < nk - 1) ? 2'b01 : 2'b00, (i < nk - 1), 0, (i == nk - 1), 0, 1);
            chk("krun.rnd_cnt",   bus.rnd_cnt,   i);
            chk("krun.key_valid", bus.key_valid, 0);
            chk("krun.st_ksize",  bus.st_ksize,  ks);
            step();
        end
        #1;
        chk_ctl("kdone", 0, 0, 2'b00, 0, 1, 0, 1, 1);
        step();
        kv_m = 1'b1;
        #1;
        chk("kend.busy",      bus.busy,      0);
        chk("kend.key_valid", bus.key_valid, 1);
    endtask

    // Requires a valid key. poke_at: step index where a kexp_start is issued (must be ignored).
    task automatic run_crypt(input bit d, input int unsigned stall_pct, input int poke_at, input int abort_at);
        int nr  = nr_of(ks_m);
        int k   = 0;
        int cyc = 0;
        bit ack;
        bit fin = 1'b0;
        bus.crypt_start = 1'b1;
        bus.dec         = d;
        #1;
        chk("crypt.err", bus.err, 0);
        step();
        bus.crypt_start = 1'b0;
        bus.dec         = ~d;
        #1;
        chk_ctl("rinit", 0, 0, 2'b10, 1, 0, 0, 0, 1);
        chk("rinit.flg_dec", bus.flg_dec, d);
        step();
        while (!fin) begin
            ack = ($urandom_range(99) >= stall_pct) || (cyc >= 200);
            bus.rnd_ack    = ack;
            bus.kexp_start = (cyc == poke_at);
            bus.ksize      = (ks_m == 2'b01) ? 2'b11 : 2'b01;
            if (cyc == abort_at) begin
                bus.rnd_ack    = 1'b0;
                bus.kexp_start = 1'b0;
                do_abort("rabort");
                return;
            end
            #1;
            chk_ctl("rreq", 0, 1, (ack && k < nr) ? 2'b11 : 2'b00, ack && (k < nr), 0, (k == nr), 0, 1);
            chk("rreq.rnd_cnt",  bus.rnd_cnt,  k);
            chk("rreq.flg_dec",  bus.flg_dec,  d);
            chk("rreq.st_ksize", bus.st_ksize, ks_m);
            chk("rreq.err",      bus.err,      0);
            if (ack) begin
                if (k == nr) fin = 1'b1;
                else         k++;
            end
            cyc++;
            step();
        end
        bus.rnd_ack    = 1'b0;
        bus.kexp_start = 1'b0;
        bus.ksize      = 2'b00;
        #1;
        chk_ctl("rdone", 0, 0, 2'b00, 0, 1, 0, 1, 1);
        step();
        #1;
        chk("rend.busy",      bus.busy,      0);
        chk("rend.key_valid", bus.key_valid, 1);
        chk("rend.st_ksize",  bus.st_ksize,  ks_m);
    endtask

    task automatic try_crypt_err();
        bus.crypt_start = 1'b1;
        #1;
        chk("nokey_crypt.err", bus.err, 1);
        step();
        bus.crypt_start = 1'b0;
        #1;
        chk("nokey_crypt.busy", bus.busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        kv_m = 1'b0;
        ks_m = 2'b00;

        //             kexp  crypt ks     dec   abrt  fin   err   busy  kv    kv_end
        tbl[0]  = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        for (int i = 0; i < 11; i++) begin
            bus.kexp_start  = tbl[i].kexp;
            bus.crypt_start = tbl[i].crypt;
            bus.ksize       = tbl[i].ks;
            bus.dec         = tbl[i].dec;
            bus.abort       = tbl[i].abrt;
            bus.rnd_ack     = 1'b1;
            #1;
            chk($sformatf("vec%0d.err", i), bus.err, tbl[i].e_err);
            step();
            idle_inputs();
            bus.rnd_ack = 1'b1;
            #1;
            chk($sformatf("vec%0d.busy", i),      bus.busy,      tbl[i].e_busy);
            chk($sformatf("vec%0d.key_valid", i), bus.key_valid, tbl[i].e_kv);
            if (tbl[i].e_busy) begin
                if (tbl[i].finish) begin
                    wait_done($sformatf("vec%0d", i), 60);
                end else begin
                    bus.abort = 1'b1;
                    #1;
                    chk($sformatf("vec%0d.abort_clr", i), bus.rk_clr, 1);
                    step();
                    bus.abort = 1'b0;
                end
            end
            #1;
            chk($sformatf("vec%0d.kv_end", i), bus.key_valid, tbl[i].e_kv_end);
            chk($sformatf("vec%0d.idle", i),   bus.busy,      0);
        end
        idle_inputs();
        kv_m = 1'b1;
        ks_m = 2'b01;

        // 128-bit expansion, then 256-bit expansion and encrypt with ack tied high.
        run_kexp(2'b01, -1);
        run_kexp(2'b11, -1);
        run_crypt(1'b0, 0, -1, -1);

        // 192-bit decrypt with random stalls and an ignored kexp_start mid-pass.
        run_kexp(2'b10, -1);
        run_crypt(1'b1, 40, 3, -1);

        // Abort at key index 5, then crypt must be rejected.
        run_kexp(2'b01, 6);
        try_crypt_err();

        for (int it = 0; it < 25; it++) begin
            int unsigned r = $urandom_range(9);
            logic [1:0]  ks;
            if (!kv_m && r < 2) begin
                try_crypt_err();
            end else if (r < 4 || !kv_m) begin
                ks = 2'($urandom_range(3));
                if (ks == 2'b00) begin
                    bus.kexp_start = 1'b1;
                    bus.ksize      = 2'b00;
                    #1;
                    chk("rnd_ks0.err", bus.err, 1);
                    step();
                    bus.kexp_start = 1'b0;
                    #1;
                    chk("rnd_ks0.busy", bus.busy,      0);
                    chk("rnd_ks0.kv",   bus.key_valid, kv_m);
                end else begin
                    run_kexp(ks, ($urandom_range(3) == 0) ? int'($urandom_range(nr_of(ks) + 1)) : -1);
                end
            end else begin
                run_crypt(1'($urandom_range(1)), $urandom_range(60), int'($urandom_range(30)),
                          ($urandom_range(4) == 0) ? int'($urandom_range(20)) : -1);
            end
        end

        // Reset in the middle of a decrypt pass.
        if (!kv_m) run_kexp(2'b11, -1);
        bus.crypt_start = 1'b1;
        bus.dec         = 1'b1;
        bus.rnd_ack     = 1'b1;
        step();
        bus.crypt_start = 1'b0;
        step();
        step();
        #1;
        chk("midrst.busy_before", bus.busy, 1);
        rst = 1'b1;
        step();
        idle_inputs();
        #1;
        chk_all_zero("midrst");
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/aria_round_seq.md
# aria_round_seq

Sequencer for the ARIA round-key address unit and round datapath. It accepts key-expansion and crypt commands and drives the address unit's `rk_op`/`rk_en`/`rk_clr`, `st_ksize` and `flg_dec` controls. It strobes round-key writes during expansion and issues one handshaked key-add step per round during encryption/decryption. It sits between the top-level command interface and the `rk_addr` generator / round datapath.

## Interface
- No parameters; key size is a run-time input.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `kexp_start` in 1: pulse; start key expansion with `ksize`.
- `crypt_start` in 1: pulse; start a crypt pass with `dec`.
- `ksize` in 2: 01=128, 10=192, 11=256; 00 reserved.
- `dec` in 1: 1=decrypt, 0=encrypt.
- `abort` in 1: synchronous abort of any running command.
- `rnd_ack` in 1: datapath accepted the current round step.
- `rk_op` out 2: 00 K_INIT, 01 K_NEXT, 10 R_INIT, 11 R_NEXT.
- `rk_en` out 1: address unit update enable.
- `rk_clr` out 1: address unit clear.
- `st_ksize` out 2: latched key size.
- `flg_dec` out 1: latched direction.
- `key_we` out 1: write the round key at the current `rk_addr`.
- `rnd_go` out 1: round step valid.
- `rnd_cnt` out 5: current key/step index.
- `rnd_last` out 1: final step of the current phase.
- `key_valid` out 1: key schedule complete for `st_ksize`.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle pulse on rejected command.

## Operation
- NR = 12/14/16 and NK = NR+1 = 13/15/17 for `st_ksize` 01/10/11.
- States are IDLE, K_INIT, K_RUN, R_INIT, R_REQ, DONE.
- **IDLE**
  - `kexp_start` with `ksize` ≠ 00: latch `st_ksize`, clear `key_valid`, go to K_INIT.
  - `kexp_start` with `ksize` = 00: pulse `err`, stay in IDLE, leave `key_valid` unchanged.
  - `crypt_start` with `key_valid` = 1: latch `flg_dec` = `dec`, go to R_INIT.
  - `crypt_start` with `key_valid` = 0: pulse `err`.
  - Both starts in the same cycle: `kexp_start` wins and `crypt_start` is dropped without `err`.
- **K_INIT**: `rk_en`=1, `rk_op`=00, `cnt`←0, go to K_RUN.
- **K_RUN**
  - Every cycle: `key_we`=1, `cnt`++.
  - `rk_en`=1, `rk_op`=01 when `cnt` < NK−1.
  - When `cnt` = NK−1: `rnd_last`=1, `rk_en`=0, go to DONE, set `key_valid`.
- **R_INIT**: `rk_en`=1, `rk_op`=10, `cnt`←0, go to R_REQ.
- **R_REQ**
  - `rnd_go`=1; hold `rnd_cnt` until `rnd_ack`.
  - On `rnd_ack` with `cnt` < NR: `rk_en`=1, `rk_op`=11, `cnt`++.
  - On `rnd_ack` with `cnt` = NR (`rnd_last`=1, the final round's second key): `rk_en`=0, go to DONE.
- **DONE**: `done`=1, `rk_clr`=1, `rk_en`=0, go to IDLE.
- **abort** in any non-IDLE state:
  - Next state is IDLE; `rk_clr`=1 that cycle; no `done`.
  - If aborted in K_INIT/K_RUN, `key_valid` stays 0.
  - `abort` in IDLE has no effect.
- Starts while `busy`=1 are ignored, with no `err`.
- `rk_clr` and `rk_en` are never asserted together.
- `cnt` is 5-bit and never wraps (max 17).
- `rnd_cnt` = `cnt`.
- `st_ksize`/`flg_dec` are stable while `busy`.
- `key_we`, `rnd_go`, `rk_*`, `rnd_last` are 0 outside the states listed.

## Timing
- Reset: state IDLE. All outputs are 0, including `key_valid`, `st_ksize`=00, `flg_dec`=0.
- Registered: state, `cnt`, `st_ksize`, `flg_dec`, `key_valid`.
- Combinational from state/`cnt`: `rk_*`, `key_we`, `rnd_go`, `rnd_last`, `done`, `busy`.
- Exception: `rk_en` in R_REQ and the R_REQ→DONE transition depend combinationally on `rnd_ack`.
- `err` is a combinational pulse in the start cycle.
- Key expansion with start at cycle T:
  - K_INIT at T+1.
  - `key_we` at T+2 … T+1+NK.
  - `done` at T+2+NK.
  - `key_valid`=1 and `busy`=0 from T+3+NK.
- Crypt with `rnd_ack` tied high: R_INIT at T+1; steps at T+2 … T+2+NR; `done` at T+3+NR.
- Each cycle of `rnd_ack` low adds one cycle to the crypt latency.
- Back-to-back: a start is accepted in the first cycle after `done` (IDLE).

## Test plan
- **Reset, then 128-bit key expansion**: reset, `kexp_start`, `ksize`=01.
  - `key_we` for 13 cycles, `rnd_cnt` 0…12, `rnd_last` at 12.
  - `rk_op`=00 once then 01 ×12.
  - `done` at T+15, `key_valid`=1.
- **Encrypt, 256-bit, `rnd_ack` high**: 17 `rnd_go` steps with `rnd_cnt` 0…16.
  - `rk_op`=10 then 11 ×16; `flg_dec`=0.
  - `done` at T+19 with `rk_clr`=1.
- **Decrypt, 192-bit, random `rnd_ack` stalls**: `rnd_cnt` holds during stalls, 15 accepted steps, `flg_dec`=1, `rk_en` only on ack.
- **Command errors**:
  - `crypt_start` after reset → `err` pulse, stays IDLE.
  - `kexp_start` with `ksize`=00 → `err`, `key_valid` unchanged.
  - Both starts together → key expansion runs, no `err`.
- **Abort mid key-expansion** at `rnd_cnt`=5: `rk_clr`=1 that cycle, IDLE next, no `done`, `key_valid`=0, and a following `crypt_start` gives `err`.
- **Ignored start and mid-run reset**: `kexp_start` during a crypt pass is ignored. `rst` mid-crypt returns all outputs to 0 and `key_valid` to 0 on the next edge.
